// File: rtl/mc_core.sv
// mc_core: small accumulator micro-controller core.
//
// Fetches one instruction word per request from an external instruction
// memory, then executes it in a single EXEC cycle. The instruction word is
// packed as {opcode, reg, data} with the opcode in the MSBs. The opcode MSB
// selects an immediate operand (data field) instead of reg_file[reg]. The
// core has a return stack for CALL/RET. Illegal opcodes and stack
// overflow/underflow raise a sticky fault and park the core in HALT.
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   rst_n      in   asynchronous active-low reset
//   imem_req   out  fetch request, high for the whole fetch wait
//   imem_addr  out  fetch address (PC)
//   imem_valid in   imem_data is valid this cycle
//   imem_data  in   fetched instruction word
//   acc_out    out  accumulator
//   flag_z     out  zero flag
//   flag_c     out  carry / borrow flag
//   halted     out  core is in HALT
//   fault      out  sticky illegal-opcode or stack error
module mc_core #(
  parameter int CNTR_WIDTH  = 8,
  parameter int OPC_WIDTH   = 5,
  parameter int REG_BIT_CNT = 3,
  parameter int DATA_WIDTH  = 16,
  parameter int STACK_DEPTH = 4,
  localparam int INSTR_WIDTH = OPC_WIDTH + REG_BIT_CNT + DATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_req,
  output logic [CNTR_WIDTH-1:0]  imem_addr,
  input  logic                   imem_valid,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic [DATA_WIDTH-1:0]  acc_out,
  output logic                   flag_z,
  output logic                   flag_c,
  output logic                   halted,
  output logic                   fault
);

  localparam int NREGS = 2 ** REG_BIT_CNT;
  // Stack pointer counts 0..STACK_DEPTH, so it needs one value more than
  // the entry index does.
  localparam int SPW   = $clog2(STACK_DEPTH + 1);
  localparam int IDXW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int SLOTS = 2 ** IDXW;

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_LD   = 4'd1,
    OP_ST   = 4'd2,
    OP_ADD  = 4'd3,
    OP_SUB  = 4'd4,
    OP_AND  = 4'd5,
    OP_OR   = 4'd6,
    OP_XOR  = 4'd7,
    OP_JMP  = 4'd8,
    OP_JZ   = 4'd9,
    OP_JC   = 4'd10,
    OP_CALL = 4'd11,
    OP_RET  = 4'd12,
    OP_HALT = 4'd13
  } op_t;

  state_t                  state, state_nxt;
  logic [INSTR_WIDTH-1:0]  ir;
  logic [CNTR_WIDTH-1:0]   pc, pc_nxt, pc_inc;
  logic [DATA_WIDTH-1:0]   acc, acc_nxt;
  logic                    z, z_nxt, c, c_nxt;
  logic                    fault_q, fault_nxt;
  logic [SPW-1:0]          sp, sp_nxt;
  logic [DATA_WIDTH-1:0]   regs  [NREGS];
  logic [CNTR_WIDTH-1:0]   stack [SLOTS];
  logic                    reg_we, push, upd_z;

  // Decoded fields of the latched instruction.
  logic [OPC_WIDTH-1:0]    opc;
  logic [REG_BIT_CNT-1:0]  rsel;
  logic [DATA_WIDTH-1:0]   dfield;
  logic [DATA_WIDTH-1:0]   operand;
  logic [CNTR_WIDTH-1:0]   target;
  op_t                     op;
  logic [DATA_WIDTH:0]     sum, diff;
  logic                    sp_full, sp_empty;
  logic [IDXW-1:0]         push_idx, pop_idx;

  assign opc      = ir[INSTR_WIDTH-1 -: OPC_WIDTH];
  assign rsel     = ir[DATA_WIDTH +: REG_BIT_CNT];
  assign dfield   = ir[DATA_WIDTH-1:0];
  assign op       = op_t'(opc[3:0]);
  assign operand  = opc[OPC_WIDTH-1] ? dfield : regs[rsel];
  assign target   = dfield[CNTR_WIDTH-1:0];
  assign pc_inc   = pc + 1'b1;
  assign sum      = {1'b0, acc} + {1'b0, operand};
  assign diff     = {1'b0, acc} - {1'b0, operand};
  assign sp_full  = (sp == SPW'(STACK_DEPTH));
  assign sp_empty = (sp == '0);
  assign push_idx = sp[IDXW-1:0];
  // sp-1 is always below STACK_DEPTH when the stack is non-empty, so the
  // truncated decrement gives the right slot.
  assign pop_idx  = sp[IDXW-1:0] - 1'b1;

  assign imem_req  = (state == S_FETCH);
  assign imem_addr = pc;
  assign acc_out   = acc;
  assign flag_z    = z;
  assign flag_c    = c;
  assign halted    = (state == S_HALT);
  assign fault     = fault_q;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    acc_nxt   = acc;
    z_nxt     = z;
    c_nxt     = c;
    sp_nxt    = sp;
    fault_nxt = fault_q;
    reg_we    = 1'b0;
    push      = 1'b0;
    upd_z     = 1'b0;
    unique case (state)
      S_FETCH: begin
        if (imem_valid) state_nxt = S_EXEC;
      end
      S_EXEC: begin
        state_nxt = S_FETCH;
        pc_nxt    = pc_inc;
        case (op)
          OP_NOP: ;
          OP_LD: begin
            acc_nxt = operand;
            c_nxt   = 1'b0;
            upd_z   = 1'b1;
          end
          OP_ST: reg_we = 1'b1;
          OP_ADD: begin
            acc_nxt = sum[DATA_WIDTH-1:0];
            c_nxt   = sum[DATA_WIDTH];
            upd_z   = 1'b1;
          end
          OP_SUB: begin
            acc_nxt = diff[DATA_WIDTH-1:0];
            c_nxt   = diff[DATA_WIDTH];
            upd_z   = 1'b1;
          end
          OP_AND: begin
            acc_nxt = acc & operand;
            c_nxt   = 1'b0;
            upd_z   = 1'b1;
          end
          OP_OR: begin
            acc_nxt = acc | operand;
            c_nxt   = 1'b0;
            upd_z   = 1'b1;
          end
          OP_XOR: begin
            acc_nxt = acc ^ operand;
            c_nxt   = 1'b0;
            upd_z   = 1'b1;
          end
          OP_JMP: pc_nxt = target;
          OP_JZ:  if (z) pc_nxt = target;
          OP_JC:  if (c) pc_nxt = target;
          OP_CALL: begin
            if (sp_full) begin
              fault_nxt = 1'b1;
              pc_nxt    = pc;
              state_nxt = S_HALT;
            end else begin
              push   = 1'b1;
              sp_nxt = sp + 1'b1;
              pc_nxt = target;
            end
          end
          OP_RET: begin
            if (sp_empty) begin
              fault_nxt = 1'b1;
              pc_nxt    = pc;
              state_nxt = S_HALT;
            end else begin
              sp_nxt = sp - 1'b1;
              pc_nxt = stack[pop_idx];
            end
          end
          OP_HALT: begin
            pc_nxt    = pc;
            state_nxt = S_HALT;
          end
          default: begin
            fault_nxt = 1'b1;
            pc_nxt    = pc;
            state_nxt = S_HALT;
          end
        endcase
        if (upd_z) z_nxt = (acc_nxt == '0);
      end
      S_HALT: ;
      default: state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      ir      <= '0;
      pc      <= '0;
      acc     <= '0;
      z       <= 1'b0;
      c       <= 1'b0;
      fault_q <= 1'b0;
      sp      <= '0;
      regs    <= '{default: '0};
      stack   <= '{default: '0};
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      acc     <= acc_nxt;
      z       <= z_nxt;
      c       <= c_nxt;
      fault_q <= fault_nxt;
      sp      <= sp_nxt;
      if (state == S_FETCH && imem_valid) ir <= imem_data;
      if (reg_we) regs[rsel] <= acc;
      if (push) stack[push_idx] <= pc_inc;
    end
  end

endmodule

// File: tb/tb_mc_core.sv
// Testbench for mc_core: an instruction-level interpreter of the ISA acts as
// reference; the bench plays the instruction memory with random wait states
// and compares architectural state after every executed instruction.
module tb_mc_core;
  localparam int CW = 8;
  localparam int OW = 5;
  localparam int RW = 3;
  localparam int DW = 16;
  localparam int SD = 4;
  localparam int IW = OW + RW + DW;

  localparam logic [4:0] NOP  = 5'h00;
  localparam logic [4:0] LDR  = 5'h01;
  localparam logic [4:0] ST   = 5'h02;
  localparam logic [4:0] ADDR = 5'h03;
  localparam logic [4:0] CALL = 5'h0B;
  localparam logic [4:0] RET  = 5'h0C;
  localparam logic [4:0] HLT  = 5'h0D;
  localparam logic [4:0] ILL  = 5'h0E;
  localparam logic [4:0] LDI  = 5'h11;
  localparam logic [4:0] ADDI = 5'h13;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          imem_req;
  logic [CW-1:0] imem_addr;
  logic          imem_valid = 1'b0;
  logic [IW-1:0] imem_data = '0;
  logic [DW-1:0] acc_out;
  logic          flag_z, flag_c, halted, fault;

  int errors = 0;
  int checks = 0;

  logic [IW-1:0] rom [256];

  // Reference architectural state.
  int m_pc, m_acc, m_z, m_c, m_halt, m_fault;
  int m_regs [8];
  int m_stack [$];

  mc_core #(
    .CNTR_WIDTH (CW),
    .OPC_WIDTH  (OW),
    .REG_BIT_CNT(RW),
    .DATA_WIDTH (DW),
    .STACK_DEPTH(SD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_valid(imem_valid),
    .imem_data (imem_data),
    .acc_out   (acc_out),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .halted    (halted),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [IW-1:0] mk(input logic [4:0] opc, input logic [2:0] r,
                                       input logic [15:0] d);
    return {opc, r, d};
  endfunction

  function automatic void model_reset();
    m_pc = 0; m_acc = 0; m_z = 0; m_c = 0; m_halt = 0; m_fault = 0;
    for (int i = 0; i < 8; i++) m_regs[i] = 0;
    m_stack.delete();
  endfunction

  function automatic void model_step(input logic [IW-1:0] ins);
    int op, r, d, opnd, s, npc;
    bit err;
    op   = int'(ins[IW-2 -: 4]);
    r    = int'(ins[DW +: RW]);
    d    = int'(ins[DW-1:0]);
    opnd = ins[IW-1] ? d : m_regs[r];
    npc  = (m_pc + 1) % 256;
    err  = 0;
    case (op)
      0: ;
      1: begin m_acc = opnd; m_c = 0; m_z = (m_acc == 0); end
      2: m_regs[r] = m_acc;
      3: begin
        s = m_acc + opnd;
        m_c = (s > 65535);
        m_acc = s % 65536;
        m_z = (m_acc == 0);
      end
      4: begin
        m_c = (m_acc < opnd);
        m_acc = (m_acc - opnd + 65536) % 65536;
        m_z = (m_acc == 0);
      end
      5: begin m_acc = m_acc & opnd; m_c = 0; m_z = (m_acc == 0); end
      6: begin m_acc = m_acc | opnd; m_c = 0; m_z = (m_acc == 0); end
      7: begin m_acc = m_acc ^ opnd; m_c = 0; m_z = (m_acc == 0); end
      8: npc = d % 256;
      9: if (m_z != 0) npc = d % 256;
      10: if (m_c != 0) npc = d % 256;
      11: begin
        if (m_stack.size() == SD) err = 1;
        else begin m_stack.push_back((m_pc + 1) % 256); npc = d % 256; end
      end
      12: begin
        if (m_stack.size() == 0) err = 1;
        else npc = m_stack.pop_back();
      end
      13: begin m_halt = 1; npc = m_pc; end
      default: err = 1;
    endcase
    if (err) begin
      m_fault = 1;
      m_halt = 1;
      npc = m_pc;
    end
    m_pc = npc;
  endfunction

  task automatic check_state();
    check("acc", 32'(acc_out), m_acc);
    check("flag_z", 32'(flag_z), m_z);
    check("flag_c", 32'(flag_c), m_c);
    check("halted", 32'(halted), m_halt);
    check("fault", 32'(fault), m_fault);
    check("imem_req", 32'(imem_req), (m_halt != 0) ? 0 : 1);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = mk(HLT, 3'd0, 16'd0);
  endtask

  task automatic random_rom();
    int sel;
    logic [3:0] op;
    for (int i = 0; i < 256; i++) begin
      sel = int'($urandom_range(99, 0));
      if (sel < 2) op = 4'(14 + sel);
      else if (sel < 5) op = 4'd13;
      else op = 4'($urandom_range(12, 0));
      rom[i] = {1'($urandom_range(1, 0)), op, 3'($urandom_range(7, 0)), 16'($urandom)};
    end
  endtask

  // Reset the core and reference; returns aligned to just after a falling edge.
  task automatic do_reset();
    imem_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_acc", 32'(acc_out), 0);
    check("rst_flags", 32'({flag_z, flag_c}), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_fault", 32'(fault), 0);
    rst_n = 1'b1;
    #1;
    check("post_rst_req", 32'(imem_req), 1);
    check("post_rst_addr", 32'(imem_addr), 0);
  endtask

  // Serve fetches from rom with random wait states in [dmin,dmax] and compare
  // architectural state after each EXEC. cycles = clock edges consumed.
  task automatic run(input int max_instr, input int dmin, input int dmax, output int cycles);
    int n, wait_cnt;
    bit exec_seen, done;
    n = 0; cycles = 0; exec_seen = 0; done = 0;
    wait_cnt = int'($urandom_range(dmax, dmin));
    while (cycles < 1500) begin
      if (exec_seen) begin
        exec_seen = 0;
        check_state();
        if (m_halt != 0 || halted || n >= max_instr) begin
          done = 1;
          break;
        end
      end
      if (imem_req) begin
        check("fetch_addr", 32'(imem_addr), m_pc);
        if (wait_cnt == 0) begin
          imem_valid = 1'b1;
          imem_data  = rom[imem_addr];
          model_step(rom[m_pc[7:0]]);
          n++;
          wait_cnt = int'($urandom_range(dmax, dmin));
        end else begin
          imem_valid = 1'b0;
          imem_data  = IW'($urandom);
          wait_cnt--;
        end
      end else begin
        // EXEC or HALT: the core must ignore the memory handshake.
        imem_valid = 1'($urandom_range(1, 0));
        imem_data  = IW'($urandom);
        exec_seen  = 1;
      end
      @(negedge clk);
      cycles++;
    end
    imem_valid = 1'b0;
    check("run_done", 32'(done), 1);
  endtask

  initial begin
    int cyc;

    // LD #5; ADD #0xFFFB; HALT with zero wait states.
    clear_rom();
    rom[0] = mk(LDI, 3'd0, 16'd5);
    rom[1] = mk(ADDI, 3'd0, 16'hFFFB);
    rom[2] = mk(HLT, 3'd0, 16'd0);
    do_reset();
    run(10, 0, 0, cyc);
    check("t1_acc", 32'(acc_out), 0);
    check("t1_z", 32'(flag_z), 1);
    check("t1_c", 32'(flag_c), 1);
    check("t1_cycles", 32'(cyc), 6);
    for (int i = 0; i < 3; i++) begin
      imem_valid = 1'b1;
      imem_data  = mk(LDI, 3'd0, 16'h1234);
      @(negedge clk);
      check("halt_hold", 32'({halted, imem_req}), 32'h2);
      check("halt_acc", 32'(acc_out), 0);
    end
    imem_valid = 1'b0;

    // Register store and register-operand add.
    clear_rom();
    rom[0] = mk(LDI, 3'd0, 16'd7);
    rom[1] = mk(ST, 3'd3, 16'd0);
    rom[2] = mk(LDI, 3'd0, 16'd0);
    rom[3] = mk(ADDR, 3'd3, 16'd0);
    do_reset();
    run(10, 0, 1, cyc);
    check("t2_acc", 32'(acc_out), 7);
    check("t2_flags", 32'({flag_z, flag_c}), 0);

    // CALL at 2 to RET at 0x10, resume at 3.
    clear_rom();
    rom[0]     = mk(NOP, 3'd0, 16'd0);
    rom[1]     = mk(NOP, 3'd0, 16'd0);
    rom[2]     = mk(CALL, 3'd0, 16'h0010);
    rom[3]     = mk(LDI, 3'd0, 16'd3);
    rom[4]     = mk(HLT, 3'd0, 16'd0);
    rom[8'h10] = mk(RET, 3'd0, 16'd0);
    do_reset();
    run(20, 0, 2, cyc);
    check("t3_acc", 32'(acc_out), 3);
    check("t3_fault", 32'(fault), 0);

    // Five nested CALLs overflow a 4-deep stack.
    clear_rom();
    for (int i = 0; i < 5; i++) rom[i] = mk(CALL, 3'd0, 16'(i + 1));
    do_reset();
    run(20, 0, 0, cyc);
    check("t3_ovf", 32'({fault, halted}), 32'h3);

    // Fixed 3-cycle fetch latency: each instruction executes once.
    clear_rom();
    rom[0] = mk(LDI, 3'd0, 16'd1);
    rom[1] = mk(ADDI, 3'd0, 16'd1);
    rom[2] = mk(HLT, 3'd0, 16'd0);
    do_reset();
    run(10, 3, 3, cyc);
    check("t4_acc", 32'(acc_out), 2);

    // Illegal opcode keeps acc.
    clear_rom();
    rom[0] = mk(LDI, 3'd0, 16'd9);
    rom[1] = mk(ILL, 3'd0, 16'hFFFF);
    do_reset();
    run(10, 0, 1, cyc);
    check("t5_acc", 32'(acc_out), 9);
    check("t5_fault", 32'({fault, halted}), 32'h3);

    // RET straight after reset underflows.
    clear_rom();
    rom[0] = mk(RET, 3'd0, 16'd0);
    do_reset();
    run(10, 0, 0, cyc);
    check("t5_ret_fault", 32'(fault), 1);

    // Reset pulse during EXEC of ADD.
    clear_rom();
    rom[0] = mk(LDI, 3'd0, 16'd1);
    rom[1] = mk(ADDI, 3'd0, 16'd2);
    rom[2] = mk(HLT, 3'd0, 16'd0);
    do_reset();
    imem_valid = 1'b1; imem_data = rom[0];
    @(negedge clk);
    imem_valid = 1'b0;
    @(negedge clk);
    imem_valid = 1'b1; imem_data = rom[1];
    @(negedge clk);
    imem_valid = 1'b0;
    check("t6_in_exec", 32'({imem_req, acc_out}), 32'h1);
    rst_n = 1'b0;
    #1;
    check("t6_async_acc", 32'(acc_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t6_rel_req", 32'(imem_req), 1);
    check("t6_rel_addr", 32'(imem_addr), 0);
    check("t6_rel_acc", 32'({acc_out, flag_z, flag_c}), 0);
    model_reset();
    run(10, 0, 1, cyc);
    check("t6_rerun_acc", 32'(acc_out), 3);

    // Random programs against the interpreter.
    for (int p = 0; p < 12; p++) begin
      random_rom();
      do_reset();
      run(50, 0, 3, cyc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
